// File: rtl/uart_i2c_usb_wb_bridge_pkg.sv
// Shared types and constants for the Wishbone to UART/I2C/USB register-bus bridge.
package uiu_bridge_pkg;

    localparam int unsigned REG_AW = 4;
    localparam int unsigned REG_DW = 32;

    localparam logic [REG_DW-1:0] UIU_ERR_DATA = 32'hDEAD_DEAD;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_e;

endpackage

// File: rtl/uart_i2c_usb_wb_bridge_if.sv
// Wishbone-classic slave signal bundle; signal suffixes are from the bridge's point of view.
interface uart_i2c_usb_wb_bridge_if;

    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [5:0]  wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;
    logic        wbs_err_o;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
        output wbs_dat_o, wbs_ack_o, wbs_err_o
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
        input  wbs_dat_o, wbs_ack_o, wbs_err_o
    );

endinterface

// File: rtl/uart_i2c_usb_wb_bridge_timer.sv
// 8-bit bus-access watchdog: clear, count, and flag when the count reaches Limit.
module uiu_bus_timer #(
    parameter int unsigned Limit = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic inc_i,
    output logic expire_o
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = 8'd0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == 8'(Limit));

endmodule

// File: rtl/uart_i2c_usb_wb_bridge.sv
// Wishbone-classic slave driving the shared UART/I2C/USB register bus.
// Optional bus timeout enabled by defining UIU_WB_TIMEOUT_EN.
module uart_i2c_usb_wb_bridge
    import uiu_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                       app_clk,
    input  logic                       app_rst,
    uart_i2c_usb_wb_bridge_if.slave    wb,
    output logic                       reg_cs,
    output logic                       reg_wr,
    output logic [REG_AW-1:0]          reg_addr,
    output logic [REG_DW-1:0]          reg_wdata,
    output logic [3:0]                 reg_be,
    input  logic [REG_DW-1:0]          reg_rdata,
    input  logic                       reg_ack,
    output logic                       timeout_o
);

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [REG_AW-1:0]   addr_q, addr_d;
    logic [REG_DW-1:0]   wdata_q, wdata_d;
    logic [3:0]          be_q, be_d;
    logic                cs_q, cs_d;
    logic [REG_DW-1:0]   rdata_q, rdata_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic                abort_q, abort_d;
    logic                expired_q, expired_d;
    logic                tout_q, tout_d;
    logic                timer_clr, timer_inc, timer_exp;
    logic [1:0]          unused_adr;

    assign unused_adr = wb.wbs_adr_i[1:0];

`ifdef UIU_WB_TIMEOUT_EN
    uiu_bus_timer #(
        .Limit (TIMEOUT_CYC)
    ) u_timer (
        .clk_i    (app_clk),
        .rst_i    (app_rst),
        .clear_i  (timer_clr),
        .inc_i    (timer_inc),
        .expire_o (timer_exp)
    );
`else
    logic unused_timer;
    assign unused_timer = timer_clr ^ timer_inc ^ (^32'(TIMEOUT_CYC));
    assign timer_exp    = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        cs_d      = cs_q;
        rdata_d   = rdata_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        abort_d   = abort_q;
        expired_d = expired_q;
        tout_d    = tout_q;
        timer_clr = 1'b0;
        timer_inc = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Skip the cycle where our own ack is still visible to the master.
                if (wb.wbs_cyc_i && wb.wbs_stb_i && !ack_q && !err_q) begin
                    we_d      = wb.wbs_we_i;
                    addr_d    = wb.wbs_adr_i[5:2];
                    wdata_d   = wb.wbs_dat_i;
                    be_d      = wb.wbs_sel_i;
                    abort_d   = 1'b0;
                    expired_d = 1'b0;
                    timer_clr = 1'b1;
                    state_d   = StAccess;
                end
            end
            StAccess: begin
                if (!wb.wbs_cyc_i) begin
                    abort_d = 1'b1;
                end
                if (!cs_q) begin
                    cs_d = 1'b1;
                end else if (reg_ack) begin
                    cs_d    = 1'b0;
                    rdata_d = we_q ? '0 : reg_rdata;
                    state_d = StResp;
                end else if (timer_exp) begin
                    cs_d      = 1'b0;
                    rdata_d   = UIU_ERR_DATA;
                    expired_d = 1'b1;
                    tout_d    = 1'b1;
                    state_d   = StResp;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
                if (wb.wbs_cyc_i && !abort_q) begin
                    err_d = expired_q;
                    ack_d = !expired_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge app_clk) begin
        if (app_rst) begin
            state_q   <= StIdle;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            cs_q      <= 1'b0;
            rdata_q   <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            abort_q   <= 1'b0;
            expired_q <= 1'b0;
            tout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            cs_q      <= cs_d;
            rdata_q   <= rdata_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            abort_q   <= abort_d;
            expired_q <= expired_d;
            tout_q    <= tout_d;
        end
    end

    assign reg_cs        = cs_q;
    assign reg_wr        = we_q;
    assign reg_addr      = addr_q;
    assign reg_wdata     = wdata_q;
    assign reg_be        = be_q;
    assign wb.wbs_dat_o  = rdata_q;
    assign wb.wbs_ack_o  = ack_q;
    assign wb.wbs_err_o  = err_q;
    assign timeout_o     = tout_q;

endmodule

// File: tb/tb_uart_i2c_usb_wb_bridge.sv
// Scoreboard bench for uart_i2c_usb_wb_bridge with a register-bus core model.
module tb_uart_i2c_usb_wb_bridge;

    localparam int TOUT = 16;

    typedef struct {
        bit          is_err;
        logic [31:0] data;
    } resp_t;

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_cs, reg_wr, reg_ack, timeout_o;
    logic [3:0]  reg_addr, reg_be;
    logic [31:0] reg_wdata, reg_rdata;

    uart_i2c_usb_wb_bridge_if wb ();

    uart_i2c_usb_wb_bridge #(
        .TIMEOUT_CYC (TOUT)
    ) dut (
        .app_clk   (clk),
        .app_rst   (rst),
        .wb        (wb),
        .reg_cs    (reg_cs),
        .reg_wr    (reg_wr),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_be    (reg_be),
        .reg_rdata (reg_rdata),
        .reg_ack   (reg_ack),
        .timeout_o (timeout_o)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    resp_t       exp_q[$];
    req_t        req_q[$];
    logic [31:0] model_mem [16];
    logic [31:0] core_mem  [16];
    int          core_delay = 0;
    int          last_cs_len = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[8*b +: 8] = dat[8*b +: 8];
        end
        return r;
    endfunction

    // Register-bus core: acks after core_delay wait cycles (-1 = never), throws stray acks.
    bit   in_acc = 1'b0;
    int   cs_cnt = 0;
    int   low_run = 100;
    req_t cur, popped;
    initial begin
        reg_ack   = 1'b0;
        reg_rdata = '0;
        for (int i = 0; i < 16; i++) core_mem[i] = '0;
    end
    always @(negedge clk) begin
        if (reg_cs) begin
            if (!in_acc) begin
                in_acc = 1'b1;
                cs_cnt = 0;
                check("cs_gap", 128'(low_run >= 1), 128'd1);
                cur = '{reg_wr, reg_addr, reg_wdata, reg_be};
                if (req_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL req_unexpected actual=addr %0h required=none", reg_addr);
                end else begin
                    popped = req_q.pop_front();
                    check("req_fields", {popped.wr, popped.addr, popped.wdata, popped.be},
                          {reg_wr, reg_addr, reg_wdata, reg_be});
                end
            end else begin
                check("req_stable", {reg_wr, reg_addr, reg_wdata, reg_be},
                      {cur.wr, cur.addr, cur.wdata, cur.be});
            end
            cs_cnt++;
            low_run = 0;
            if (core_delay >= 0 && cs_cnt == core_delay + 1) begin
                reg_ack   = 1'b1;
                reg_rdata = core_mem[reg_addr];
                if (reg_wr) core_mem[reg_addr] = merge(core_mem[reg_addr], reg_wdata, reg_be);
            end else begin
                reg_ack   = 1'b0;
                reg_rdata = $urandom();
            end
        end else begin
            if (in_acc) begin
                in_acc      = 1'b0;
                last_cs_len = cs_cnt;
            end
            low_run++;
            reg_ack   = ($urandom_range(0, 7) == 0);
            reg_rdata = $urandom();
        end
    end

    // Response monitor.
    bit    prev_resp = 1'b0;
    resp_t got;
    always @(negedge clk) begin
        if (!rst && (wb.wbs_ack_o || wb.wbs_err_o)) begin
            check("resp_single", 128'(prev_resp), 128'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp_unexpected actual=ack %0b err %0b required=none",
                         wb.wbs_ack_o, wb.wbs_err_o);
            end else begin
                got = exp_q.pop_front();
                check("resp_kind", {wb.wbs_ack_o, wb.wbs_err_o}, {!got.is_err, got.is_err});
                check("resp_data", wb.wbs_dat_o, got.data);
            end
            prev_resp = 1'b1;
        end else begin
            prev_resp = 1'b0;
        end
    end

    task automatic drive_idle();
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
    endtask

    task automatic xfer(input bit we, input logic [5:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int delay, input bit abort_it,
                        input bit exp_err);
        resp_t      e;
        req_t       r;
        int         n;
        logic [3:0] idx;
        idx        = adr[5:2];
        core_delay = delay;
        r          = '{we, idx, dat, sel};
        req_q.push_back(r);
        if (!abort_it) begin
            e.is_err = exp_err;
            e.data   = exp_err ? 32'hDEAD_DEAD : (we ? 32'h0 : model_mem[idx]);
            exp_q.push_back(e);
        end
        if (we && !exp_err) model_mem[idx] = merge(model_mem[idx], dat, sel);
        @(posedge clk);
        #1;
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_we_i  = we;
        wb.wbs_adr_i = adr;
        wb.wbs_dat_i = dat;
        wb.wbs_sel_i = sel;
        n = 0;
        if (abort_it) begin
            while (!reg_cs && n < 50) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("abort_cs_seen", 128'(reg_cs), 128'd1);
            drive_idle();
            n = 0;
            while (reg_cs && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
            repeat (3) @(posedge clk);
            #1;
        end else begin
            do begin
                @(posedge clk);
                #1;
                n++;
            end while (!(wb.wbs_ack_o || wb.wbs_err_o) && n < 100);
            check("latency", 128'(n - 1), 128'(exp_err ? 3 + TOUT : 3 + delay));
            drive_idle();
        end
    endtask

    initial begin
        req_t rr;
        int   n;
        rst = 1'b1;
        drive_idle();
        wb.wbs_we_i  = 1'b0;
        wb.wbs_adr_i = '0;
        wb.wbs_dat_i = '0;
        wb.wbs_sel_i = '0;
        for (int i = 0; i < 16; i++) model_mem[i] = '0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {reg_cs, reg_wr, reg_addr, reg_wdata, reg_be, wb.wbs_dat_o,
              wb.wbs_ack_o, wb.wbs_err_o, timeout_o}, 128'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        xfer(1'b1, 6'h08, 32'h0000_00A5, 4'h1, 0, 1'b0, 1'b0);
        check("t1_cs_len", 128'(last_cs_len), 128'd1);
        xfer(1'b1, 6'h3C, 32'h1234_5678, 4'hF, 0, 1'b0, 1'b0);
        xfer(1'b0, 6'h3C, 32'h0, 4'hF, 5, 1'b0, 1'b0);
        check("t2_cs_len", 128'(last_cs_len), 128'd6);
        check("t2_dat_hold", wb.wbs_dat_o, 32'h1234_5678);
        xfer(1'b1, 6'h10, 32'hCAFE_F00D, 4'hF, 1, 1'b0, 1'b0);
        xfer(1'b1, 6'h14, 32'h0BAD_BEEF, 4'h6, 0, 1'b0, 1'b0);
        xfer(1'b0, 6'h10, 32'h0, 4'hF, 2, 1'b0, 1'b0);
        xfer(1'b0, 6'h14, 32'h0, 4'hF, 0, 1'b0, 1'b0);

`ifdef UIU_WB_TIMEOUT_EN
        check("tout_before", 128'(timeout_o), 128'd0);
        xfer(1'b0, 6'h20, 32'h0, 4'hF, -1, 1'b0, 1'b1);
        check("tout_sticky", 128'(timeout_o), 128'd1);
        xfer(1'b0, 6'h3C, 32'h0, 4'hF, TOUT, 1'b0, 1'b0);
`else
        xfer(1'b0, 6'h3C, 32'h0, 4'hF, TOUT, 1'b0, 1'b0);
        check("tout_tied", 128'(timeout_o), 128'd0);
`endif

        xfer(1'b1, 6'h24, 32'h5A5A_0001, 4'hF, 3, 1'b1, 1'b0);
        xfer(1'b0, 6'h24, 32'h0, 4'hF, 0, 1'b1, 1'b0);
        xfer(1'b0, 6'h24, 32'h0, 4'hF, 1, 1'b0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            xfer(1'($urandom()), 6'($urandom()), $urandom(), 4'($urandom()),
                 int'($urandom_range(0, 6)), ($urandom_range(0, 7) == 0), 1'b0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        // Reset while the core is still holding off its ack.
        core_delay = 10;
        rr = '{1'b0, 4'h5, 32'h7777_7777, 4'hF};
        req_q.push_back(rr);
        @(posedge clk);
        #1;
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_adr_i = 6'h14;
        wb.wbs_dat_i = 32'h7777_7777;
        wb.wbs_sel_i = 4'hF;
        n = 0;
        while (!reg_cs && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("rst_cs_seen", 128'(reg_cs), 128'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive_idle();
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_outputs", {reg_cs, reg_wr, reg_addr, reg_wdata, reg_be, wb.wbs_dat_o,
              wb.wbs_ack_o, wb.wbs_err_o, timeout_o}, 128'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        xfer(1'b0, 6'h10, 32'h0, 4'hF, 2, 1'b0, 1'b0);

        repeat (10) @(posedge clk);
        check("resp_drained", 128'(exp_q.size()), 128'd0);
        check("req_drained", 128'(req_q.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
